// File: rtl/data_bus_responder.sv
// Data-memory responder for the single-cycle core: byte-writable RAM in the low half,
// MMIO window (console TX FIFO, cycle counter, dropped-byte counter) in the high half.
module data_bus_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_DROPS  = 2'd3
  } mmio_reg_e;

  logic            ram_sel;
  logic            mmio_sel;
  mmio_reg_e       mmio_reg;
  logic [AW-1:0]   ram_idx;

  assign ram_sel  = ~daddr[31];
  assign mmio_sel = daddr[31];
  assign mmio_reg = mmio_reg_e'(daddr[3:2]);
  assign ram_idx  = daddr[AW+1:2];

  // Address bits that alias: byte offset and the gap above the decoded fields.
  logic unused_addr;
  assign unused_addr = ^{daddr[30:AW+2], daddr[1:0]};

  // RAM: no reset on the array; writes are held off while reset is asserted.
  logic [31:0] ram [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (reset && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          drop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_sel && (mmio_reg == REG_TXDATA) && dwe[0];
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && push_ok) fifo_mem[wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [31:0] cycle_cnt;
  logic [15:0] drops_cnt;
  logic        cycle_clr;
  logic        drops_clr;

  assign cycle_clr = mmio_sel && (mmio_reg == REG_CYCLE) && (|dwe);
  assign drops_clr = mmio_sel && (mmio_reg == REG_DROPS) && (|dwe);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      drops_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_clr ? 32'h0 : cycle_cnt + 32'h1;
      if (drops_clr)
        drops_cnt <= '0;
      else if (drop && (drops_cnt != 16'hFFFF))
        drops_cnt <= drops_cnt + 16'h1;
    end
  end

  logic [31:0] status_word;
  assign status_word = {16'h0000, 8'(count), 6'b000000, full, empty};

  always_comb begin
    drdata = 32'h0;
    if (ram_sel) begin
      drdata = ram[ram_idx];
    end else begin
      case (mmio_reg)
        REG_TXDATA: drdata = 32'h0;
        REG_STATUS: drdata = status_word;
        REG_CYCLE:  drdata = cycle_cnt;
        REG_DROPS:  drdata = {16'h0000, drops_cnt};
        default:    drdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: vector table for RAM/FIFO/MMIO behaviour, scoreboard
// queue for the TX byte stream, hand sequences for counter wrap, saturation and reset.
module tb_data_bus_responder;

  localparam int MEM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_TX     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
  localparam logic [31:0] A_DROPS  = 32'h8000_000C;
  localparam logic [31:0] A_RAM    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  data_bus_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        ready;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] we, input logic rdy, input logic chk,
                              input logic [31:0] exp);
    vec_t v;
    v.name = nm; v.addr = a; v.wdata = wd; v.we = we; v.ready = rdy; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Called at the negedge before the commit edge: checks the stream and updates the model.
  task automatic sb_cycle();
    logic       pop;
    logic       push_req;
    logic [7:0] b;
    check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
    pop = (exp_q.size() != 0) && tx_ready;
    if (exp_q.size() == 0) begin
      check("tx_data_empty", {24'b0, tx_data}, 32'h0);
    end else if (pop) begin
      b = exp_q.pop_front();
      check("tx_data", {24'b0, tx_data}, {24'b0, b});
    end
    push_req = daddr[31] && (daddr[3:2] == 2'd0) && dwe[0];
    if (push_req && ((exp_q.size() < FIFO_DEPTH) || pop)) exp_q.push_back(dwdata[7:0]);
  endtask

  task automatic step(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input logic rdy, input logic chk,
                      input logic [31:0] exp);
    daddr = a; dwdata = wd; dwe = we; tx_ready = rdy;
    @(negedge clk);
    if (chk) check(nm, drdata, exp);
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    // RAM byte lanes and aliasing
    add("ram_wr_full", A_RAM, 32'h1122_3344, 4'b1111, 1'b0, 1'b0, 32'h0);
    add("ram_wr_b0",   A_RAM, 32'h0000_00AA, 4'b0001, 1'b0, 1'b0, 32'h0);
    add("ram_wr_b3",   A_RAM, 32'hBB00_0000, 4'b1000, 1'b0, 1'b0, 32'h0);
    add("ram_rd",      A_RAM, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hBB22_33AA);
    add("ram_alias",   A_RAM + 32'(4 * MEM_WORDS), 32'h0, 4'b0000, 1'b0, 1'b1, 32'hBB22_33AA);
    // Fill beyond capacity, then drain
    for (int i = 1; i <= 10; i++)
      add("txdata_rd", A_TX, 32'(i), 4'b0001, 1'b0, 1'b1, 32'h0);
    add("status_full", A_STATUS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_0802);
    add("drops_2",     A_DROPS,  32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_0002);
    for (int k = 0; k < 8; k++)
      add("status_drain", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1,
          (32'(8 - k) << 8) | ((k == 0) ? 32'h2 : 32'h0));
    add("status_empty", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0000_0001);
    // Full FIFO with simultaneous push and pop
    add("drops_clr",   A_DROPS, 32'h0, 4'b1111, 1'b0, 1'b0, 32'h0);
    add("drops_zero",  A_DROPS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++)
      add("fill", A_TX, 32'h20 + 32'(i), 4'b0001, 1'b0, 1'b0, 32'h0);
    add("push_pop_full", A_TX, 32'h0000_0055, 4'b0001, 1'b1, 1'b0, 32'h0);
    add("status_still_full", A_STATUS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_0802);
    add("drops_unchanged",   A_DROPS,  32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 8; k++)
      add("status_drain2", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1,
          (32'(8 - k) << 8) | ((k == 0) ? 32'h2 : 32'h0));
    add("status_empty2", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0000_0001);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    daddr = A_STATUS; #1 check("rst_status", drdata, 32'h1);
    daddr = A_CYCLE;  #1 check("rst_cycle", drdata, 32'h0);
    daddr = A_DROPS;  #1 check("rst_drops", drdata, 32'h0);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].ready,
           vecs[i].chk, vecs[i].exp);

    // Cycle counter clear and wrap
    step("cycle_wr",  A_CYCLE, 32'hDEAD_BEEF, 4'b0010, 1'b0, 1'b0, 32'h0);
    step("cycle_clr", A_CYCLE, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    step("cycle_inc", A_CYCLE, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h1);
    step("cycle_inc2", A_CYCLE, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h2);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt;
    step("cycle_max",  A_CYCLE, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("cycle_wrap", A_CYCLE, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);

    // DROPS saturation and clear
    for (int i = 0; i < 8; i++)
      step("fill3", A_TX, 32'h30 + 32'(i), 4'b0001, 1'b0, 1'b0, 32'h0);
    force dut.drops_cnt = 16'hFFFF;
    #1 release dut.drops_cnt;
    step("drop_push", A_TX, 32'h0000_0099, 4'b0001, 1'b0, 1'b0, 32'h0);
    step("drops_sat", A_DROPS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_FFFF);
    step("drops_wr",  A_DROPS, 32'h0, 4'b0100, 1'b0, 1'b0, 32'h0);
    step("drops_cleared", A_DROPS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);

    // Async reset mid-stream with three bytes queued
    for (int i = 0; i < 5; i++)
      step("drain5", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1, 32'(8 - i) << 8 | ((i == 0) ? 32'h2 : 32'h0));
    check("three_left", exp_q.size(), 32'd3);
    daddr = A_STATUS; dwe = 4'b0000; tx_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_tx_data", {24'b0, tx_data}, 32'h0);
    check("async_status", drdata, 32'h1);
    daddr = A_RAM;
    #1 check("async_ram", drdata, 32'hBB22_33AA);
    exp_q.delete();
    @(posedge clk);
    daddr = A_CYCLE;
    #1 check("rst_cycle_held", drdata, 32'h0);
    @(negedge clk); #1 reset = 1'b1;
    #1 check("rel_cycle_zero", drdata, 32'h0);
    @(posedge clk); #1;
    step("rel_cycle_one", A_CYCLE, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h1);
    step("rel_status", A_STATUS, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h1);
    step("rel_ram", A_RAM, 32'h0, 4'b0000, 1'b1, 1'b1, 32'hBB22_33AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder for the CPU data-memory port: it receives `daddr`/`dwdata`/`dwe` from the core and returns `drdata`. The low half of the address space is a byte-writable RAM. The high half is an MMIO window containing:

- a console transmit FIFO, drained through a valid/ready byte stream,
- a free-running cycle counter,
- a dropped-byte counter.

Reads are combinational so the single-cycle core sees data in the same cycle; all writes take effect at the rising clock edge.

## Interface
Parameters:
- `MEM_WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..128.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all non-RAM state immediately.
- `daddr`  in  32  byte address from core.
- `dwdata`  in  32  write data, byte lanes already replicated by core.
- `dwe`  in  4  per-byte write enable; `dwe[i]` covers `dwdata[8i+7:8i]`.
- `drdata`  out  32  read data for `daddr`, combinational.
- `tx_data`  out  8  FIFO head byte; 0 when FIFO empty.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts head byte this cycle.

## Operation
- **Decode.** `daddr[31]`=0 selects RAM; `daddr[31]`=1 selects MMIO. `daddr[1:0]` is ignored everywhere; byte/half selection is done by the core.
- **RAM.**
  - Word index = `daddr[log2(MEM_WORDS)+1:2]`; higher bits alias.
  - At each edge, for every `dwe[i]`=1, byte i of the addressed word ← `dwdata[8i+7:8i]`.
  - RAM is not reset; contents are undefined until written.
- **MMIO** is decoded by `daddr[3:2]` only; `daddr[30:4]` alias.
  - `0x0` TXDATA:
    - Write with `dwe[0]`=1 pushes `dwdata[7:0]`; other lanes are ignored.
    - Reads return 0.
  - `0x4` STATUS, read-only:
    - bit0 = empty, bit1 = full, bits[15:8] = occupancy count; all other bits 0.
    - Writes are ignored.
  - `0x8` CYCLE:
    - 32-bit counter, +1 every edge, wraps from 0xFFFFFFFF to 0.
    - Any write (any `dwe` bit) loads 0; the clear wins over the increment.
  - `0xC` DROPS:
    - 16-bit count of rejected pushes, zero-extended on read; saturates at 0xFFFF.
    - Any write clears it; if a clear and a drop happen in the same cycle, the result is 0.
- **FIFO**
  - First-word-fall-through: `tx_data` = head entry, `tx_valid` = !empty.
  - Pop occurs when `tx_valid && tx_ready`.
  - A push is accepted if count < `FIFO_DEPTH` or a pop occurs in the same cycle. When full with a simultaneous push and pop, count is unchanged and the byte is accepted.
  - A push into a full FIFO with no same-cycle pop is dropped and DROPS increments.
  - Read/write pointers wrap modulo `FIFO_DEPTH`; count ranges 0..`FIFO_DEPTH`.
- **Reset.**
  - FIFO pointers, count, CYCLE and DROPS go to 0.
  - `tx_valid`=0 and `tx_data`=0 immediately when `reset` falls, including mid-transfer; a byte not yet popped is lost.
  - After release, counting and accepting writes starts at the first rising edge with `reset`=1.
  - `drdata` stays combinational throughout reset: RAM reads return the unchanged array contents, and MMIO reads return the reset values.

## Timing
- **Read latency:** 0 cycles. `drdata` follows `daddr` and the current state combinationally.
- **Write visibility:** RAM, CYCLE and DROPS writes are visible on `drdata` in the cycle after the edge.
- **Push timing:** a push at edge N raises `tx_valid` after edge N. Its data is on `tx_data` in cycle N+1 if the FIFO was empty.
- **Pop timing:** a pop at edge N advances `tx_data` to the next entry after edge N.
- **Sink independence:** `tx_ready` may be held high continuously, sustaining one byte per cycle. `tx_valid` never depends on `tx_ready`.
- **Read/write ordering:** a CYCLE read returns the pre-edge value. A read of STATUS in the same cycle as a push reflects the pre-push state.

## Test plan
1. **RAM byte lanes.** Write 0x11223344 to 0x100 with `dwe`=1111, then 0x000000AA with `dwe`=0001, then 0xBB000000 with `dwe`=1000. Expect a read of 0x100 = 0xBB2233AA and a read of 0x100+4·`MEM_WORDS` = the same word (alias).
2. **FIFO fill, overflow, drain.** With `tx_ready`=0, push bytes 1..10 with `FIFO_DEPTH`=8. Expect STATUS = 0x0802 and DROPS = 2. Then raise `tx_ready`; expect `tx_data` = 1..8 on consecutive cycles, after which `tx_valid`=0 and STATUS = 0x0001.
3. **Full with simultaneous push/pop.** Fill 8 entries, then push 0x55 in the same cycle as `tx_ready`=1. Expect count to stay 8, DROPS unchanged, and 0x55 to emerge eighth.
4. **Cycle counter.** Read CYCLE on two consecutive cycles and expect values differing by 1. Write CYCLE, then read on the next cycle and expect 0. Separately, bring the counter to 0xFFFFFFFF (hierarchical force or a long run) and expect the following value to be 0.
5. **DROPS saturation and clear.** Force DROPS to 0xFFFF, then drop a push; expect it to remain 0xFFFF. Write DROPS; expect 0.
6. **Async reset mid-stream.** With 3 bytes queued and `tx_ready`=1, pull `reset` low between edges. Expect `tx_valid`=0 and `tx_data`=0 with no clock edge. After release, expect STATUS = 0x0001 and CYCLE to restart at 0, while previously written RAM data is unchanged.
